huffman_encoder: RTL and testbench

Serializes 3-bit symbol codes (A=1 … F=6) into the team's fixed prefix-free Huffman bitstream, one bit per clock, MSB of each codeword first. It is the transmit-side counterpart of the serial Huffman decoder. Its `x`/`x_valid` output drives that decoder's serial bit input directly. Symbols enter through a valid/ready handshake, and back-to-back symbols produce a gap-free bitstream.

---
 rtl/huffman_encoder_if.sv | 28 ++
 rtl/huffman_encoder.sv | 105 ++++++++++
 tb/tb_huffman_encoder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/huffman_encoder_if.sv
// Symbol handshake and serial bit-line bundle for the Huffman encoder.
// The master side presents symbols and consumes the serial bitstream.
interface huffman_encoder_if;
  logic [2:0] sym;
  logic       sym_valid;
  logic       sym_ready;
  logic       x;
  logic       x_valid;
  logic       err;

  modport master (
    output sym,
    output sym_valid,
    input  sym_ready,
    input  x,
    input  x_valid,
    input  err
  );

  modport slave (
    input  sym,
    input  sym_valid,
    output sym_ready,
    output x,
    output x_valid,
    output err
  );
endinterface

// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: symbols 1..6 become prefix-free codewords, MSB first, one bit per clock.
// Define HUFF_ENC_STATS_EN to add the 16-bit wrapping bit_count_o counter of emitted bits.
module huffman_encoder (
  input  logic              clk,
  input  logic              reset,
`ifdef HUFF_ENC_STATS_EN
  output logic [15:0]       bit_count_o,
`endif
  huffman_encoder_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state_q, state_d;
  logic [3:0] shreg_q, shreg_d;
  logic [2:0] rem_q, rem_d;
  logic       err_q, err_d;

  logic [3:0] codeWord;
  logic [2:0] codeLen;
  logic       symLegal;
  logic       symAccept;

  // Codewords are stored left-aligned so the next bit is always shreg_q[3].
  always_comb begin
    codeWord = 4'b0000;
    codeLen  = 3'd0;
    symLegal = 1'b1;
    case (bus.sym)
      3'd1: begin codeWord = 4'b0000; codeLen = 3'd1; end
      3'd2: begin codeWord = 4'b1010; codeLen = 3'd3; end
      3'd3: begin codeWord = 4'b1000; codeLen = 3'd3; end
      3'd4: begin codeWord = 4'b1110; codeLen = 3'd3; end
      3'd5: begin codeWord = 4'b1101; codeLen = 3'd4; end
      3'd6: begin codeWord = 4'b1100; codeLen = 3'd4; end
      default: symLegal = 1'b0;
    endcase
  end

  assign bus.sym_ready = (state_q == IDLE) || (rem_q == 3'd1);
  assign symAccept     = bus.sym_valid && bus.sym_ready;

  // An accept on the last bit overrides the shift so the next codeword follows with no gap.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    if (state_q == SHIFT) begin
      shreg_d = {shreg_q[2:0], 1'b0};
      rem_d   = rem_q - 3'd1;
      if (rem_q == 3'd1) begin
        state_d = IDLE;
      end
    end
    if (symAccept) begin
      if (symLegal) begin
        shreg_d = codeWord;
        rem_d   = codeLen;
        state_d = SHIFT;
      end else begin
        shreg_d = 4'b0000;
        rem_d   = 3'd0;
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= 4'b0000;
      rem_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Every codeword shifts out to all zeros, so x is already 0 whenever the line is idle.
  assign bus.x       = shreg_q[3];
  assign bus.x_valid = (state_q == SHIFT);
  assign bus.err     = err_q;

`ifdef HUFF_ENC_STATS_EN
  logic [15:0] bitCount_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitCount_q <= 16'd0;
    end else if (state_q == SHIFT) begin
      bitCount_q <= bitCount_q + 16'd1;
    end
  end

  assign bit_count_o = bitCount_q;
`else
  // Statistics disabled: no bit counter is built.
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Scoreboard bench for huffman_encoder: the driver queues expected bits/errors, a monitor checks them.
// Also exercises the HUFF_ENC_STATS_EN counter when that macro is defined.
module tb_huffman_encoder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  huffman_encoder_if bus ();

`ifdef HUFF_ENC_STATS_EN
  logic [15:0] bitCount;
`endif

  huffman_encoder dut (
    .clk         (clk),
    .reset       (reset),
`ifdef HUFF_ENC_STATS_EN
    .bit_count_o (bitCount),
`endif
    .bus         (bus)
  );

  // Right-aligned codewords, hand-written from the code table.
  int codeTab [7] = '{0, 'b0, 'b101, 'b100, 'b111, 'b1101, 'b1100};
  int lenTab  [7] = '{0, 1, 3, 3, 3, 4, 4};

  int compareCount = 0;
  int failCount    = 0;
  int cyc          = 0;
  int run          = 0;
  int lastRun      = 0;
  bit expErr;
  bit expBits [$];
  int errQ    [$];
  int w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops one expected bit per valid cycle and checks err against its expected cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.x_valid) begin
        if (expBits.size() == 0) checkOutput("spuriousBit", {31'd0, bus.x_valid}, 32'd0);
        else checkOutput("bit", {31'd0, bus.x}, {31'd0, expBits.pop_front()});
        run++;
      end else if (run > 0) begin
        lastRun = run;
        run = 0;
      end
      expErr = (errQ.size() > 0) && (errQ[0] == cyc);
      if (expErr) void'(errQ.pop_front());
      if (expErr || bus.err) checkOutput("err", {31'd0, bus.err}, {31'd0, expErr});
    end
  end

  task automatic applyStimulus(input logic [2:0] s, output int waits);
    logic [3:0] code;
    @(negedge clk);
    bus.sym = s;
    bus.sym_valid = 1'b1;
    waits = 0;
    while (!bus.sym_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.sym_ready) begin
      checkOutput("readyTimeout", {31'd0, bus.sym_ready}, 32'd1);
      bus.sym_valid = 1'b0;
      return;
    end
    if (s >= 3'd1 && s <= 3'd6) begin
      code = 4'(codeTab[s]);
      for (int i = lenTab[s] - 1; i >= 0; i--) expBits.push_back(code[i]);
    end else begin
      errQ.push_back(cyc + 1);
    end
    @(posedge clk);
  endtask

  task automatic idleInputs();
    @(negedge clk);
    bus.sym_valid = 1'b0;
    bus.sym = 3'd0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    bus.sym_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.sym = 3'd0;
    bus.sym_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetValid", {31'd0, bus.x_valid}, 32'd0);
    checkOutput("resetX", {31'd0, bus.x}, 32'd0);
    checkOutput("resetErr", {31'd0, bus.err}, 32'd0);
    checkOutput("resetReady", {31'd0, bus.sym_ready}, 32'd1);
`ifdef HUFF_ENC_STATS_EN
    checkOutput("resetCount", {16'd0, bitCount}, 32'd0);
`endif
    reset = 1'b0;

    // Single A: one bit, then idle with ready high.
    applyStimulus(3'd1, w);
    idleInputs();
    @(negedge clk);
    checkOutput("idleValidA", {31'd0, bus.x_valid}, 32'd0);
    checkOutput("idleReadyA", {31'd0, bus.sym_ready}, 32'd1);

    // B, F, A back to back: 8 gap-free bits.
    applyStimulus(3'd2, w);
    applyStimulus(3'd6, w);
    checkOutput("waitF", w, 32'd2);
    applyStimulus(3'd1, w);
    checkOutput("waitA", w, 32'd3);
    idleInputs();
    repeat (3) @(negedge clk);
    checkOutput("runBFA", lastRun, 32'd8);

    // D then E presented early: ready low for 2 cycles, 7 bits.
    applyStimulus(3'd4, w);
    applyStimulus(3'd5, w);
    checkOutput("readyLowD", w, 32'd2);
    idleInputs();
    repeat (5) @(negedge clk);
    checkOutput("runDE", lastRun, 32'd7);

    // Illegal 7 from idle, then C.
    applyStimulus(3'd7, w);
    idleInputs();
    checkOutput("illegalNoBit", {31'd0, bus.x_valid}, 32'd0);
    applyStimulus(3'd3, w);
    idleInputs();
    repeat (4) @(negedge clk);
    checkOutput("runC", lastRun, 32'd3);

    // Illegal 0 on the last bit of B: line drops the following cycle.
    applyStimulus(3'd2, w);
    applyStimulus(3'd0, w);
    idleInputs();
    checkOutput("illegalLastDrop", {31'd0, bus.x_valid}, 32'd0);
    checkOutput("illegalLastReady", {31'd0, bus.sym_ready}, 32'd1);
    repeat (3) @(negedge clk);

    // Reset during the 2nd bit of E: remaining bits discarded.
    applyStimulus(3'd5, w);
    idleInputs();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkOutput("resetMidValid", {31'd0, bus.x_valid}, 32'd0);
    expBits.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("readyAfterReset", {31'd0, bus.sym_ready}, 32'd1);
    checkOutput("runPartialE", lastRun, 32'd2);

`ifdef HUFF_ENC_STATS_EN
    doReset();
    for (int s = 1; s <= 6; s++) applyStimulus(3'(s), w);
    idleInputs();
    repeat (6) @(negedge clk);
    checkOutput("count18", {16'd0, bitCount}, 32'd18);
    doReset();
    for (int i = 0; i < 65535; i++) applyStimulus(3'd1, w);
    idleInputs();
    repeat (4) @(negedge clk);
    checkOutput("countMax", {16'd0, bitCount}, 32'd65535);
    applyStimulus(3'd1, w);
    idleInputs();
    repeat (4) @(negedge clk);
    checkOutput("countWrap", {16'd0, bitCount}, 32'd0);
`endif

    repeat (4) @(negedge clk);
    checkOutput("bitQueueEmpty", expBits.size(), 32'd0);
    checkOutput("errQueueEmpty", errQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
